// File: rtl/toy_st_drain.sv
// toy_st_drain: store drain buffer between the store queue and the data-memory bus.
// Committed stores enter over a valid/ready handshake and sit in a small FIFO.
// They leave in order to the bus, with a cap on writes that are issued but not yet
// acknowledged. A store fence blocks new stores until everything buffered and
// outstanding has been acknowledged, then pulses fence_done.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_vld/in_rdy, in_*        store write request from the store queue
//   bus_req_vld/rdy, bus_req_* head-of-buffer write request to the bus
//   bus_ack_vld                one write acknowledged (pulse)
//   fence_req / fence_done     fence request pulse / fence complete pulse
//   drain_empty                buffer empty and nothing outstanding
//   outst_cnt                  writes issued but not yet acknowledged
//   ack_err                    sticky: acknowledge arrived with nothing outstanding
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | normal operation, stores accepted
// FENCE | stores blocked, waiting for buffer empty and no writes outstanding
// DONE  | fence complete, fence_done high for this one cycle

module toy_st_drain #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SB_W      = 23,
    parameter int MAX_OUTST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [DATA_W/8-1:0]   in_strb,
    input  logic [SB_W-1:0]       in_sb,
    output logic                  bus_req_vld,
    input  logic                  bus_req_rdy,
    output logic [ADDR_W-1:0]     bus_req_addr,
    output logic [DATA_W-1:0]     bus_req_data,
    output logic [DATA_W/8-1:0]   bus_req_strb,
    output logic [SB_W-1:0]       bus_req_sb,
    input  logic                  bus_ack_vld,
    input  logic                  fence_req,
    output logic                  fence_done,
    output logic                  drain_empty,
    output logic [3:0]            outst_cnt,
    output logic                  ack_err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FENCE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [STRB_W-1:0] mem_strb [DEPTH];
    logic [SB_W-1:0]   mem_sb   [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       outst_nxt;
    logic             in_fire, bus_fire, ack_ok;

    // in_rdy and bus_req_vld depend only on registered state, so there is no
    // combinational path from bus_req_rdy back to in_rdy.
    assign in_rdy      = (cnt != CNT_FULL) && (state == S_IDLE);
    assign bus_req_vld = (cnt != '0) && (outst_cnt < 4'(MAX_OUTST));
    assign in_fire     = in_vld && in_rdy;
    assign bus_fire    = bus_req_vld && bus_req_rdy;
    assign ack_ok      = bus_ack_vld && (outst_cnt != 4'd0);
    assign drain_empty = (cnt == '0) && (outst_cnt == 4'd0);
    assign fence_done  = (state == S_DONE);

    assign bus_req_addr = mem_addr[rd_ptr];
    assign bus_req_data = mem_data[rd_ptr];
    assign bus_req_strb = mem_strb[rd_ptr];
    assign bus_req_sb   = mem_sb[rd_ptr];

    // Storage is cleared on reset so the payload outputs read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
                mem_strb[i] <= '0;
                mem_sb[i]   <= '0;
            end
        end else if (in_fire) begin
            mem_addr[wr_ptr] <= in_addr;
            mem_data[wr_ptr] <= in_data;
            mem_strb[wr_ptr] <= in_strb;
            mem_sb[wr_ptr]   <= in_sb;
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (in_fire && !bus_fire)
            cnt_nxt = cnt + CNT_ONE;
        else if (!in_fire && bus_fire)
            cnt_nxt = cnt - CNT_ONE;
    end

    // A spurious acknowledge (nothing outstanding) never decrements; it only
    // flags ack_err, so a same-cycle issue still counts up.
    always_comb begin
        outst_nxt = outst_cnt;
        if (bus_fire && !ack_ok)
            outst_nxt = outst_cnt + 4'd1;
        else if (!bus_fire && ack_ok)
            outst_nxt = outst_cnt - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            outst_cnt <= 4'd0;
            ack_err   <= 1'b0;
            state     <= S_IDLE;
        end else begin
            if (in_fire)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (bus_fire)
                rd_ptr <= rd_ptr + PTR_W'(1);
            cnt       <= cnt_nxt;
            outst_cnt <= outst_nxt;
            if (bus_ack_vld && (outst_cnt == 4'd0))
                ack_err <= 1'b1;
            state     <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fence_req) state_nxt = S_FENCE;
            S_FENCE: if (drain_empty) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_toy_st_drain.sv
module tb_toy_st_drain;

    localparam int DEPTH     = 4;
    localparam int MAX_OUTST = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld, in_rdy;
    logic [31:0] in_addr, in_data;
    logic [3:0]  in_strb;
    logic [22:0] in_sb;
    logic        bus_req_vld, bus_req_rdy;
    logic [31:0] bus_req_addr, bus_req_data;
    logic [3:0]  bus_req_strb;
    logic [22:0] bus_req_sb;
    logic        bus_ack_vld, fence_req, fence_done, drain_empty, ack_err;
    logic [3:0]  outst_cnt;

    toy_st_drain #(
        .DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .SB_W(23), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr), .in_data(in_data),
        .in_strb(in_strb), .in_sb(in_sb),
        .bus_req_vld(bus_req_vld), .bus_req_rdy(bus_req_rdy),
        .bus_req_addr(bus_req_addr), .bus_req_data(bus_req_data),
        .bus_req_strb(bus_req_strb), .bus_req_sb(bus_req_sb),
        .bus_ack_vld(bus_ack_vld), .fence_req(fence_req), .fence_done(fence_done),
        .drain_empty(drain_empty), .outst_cnt(outst_cnt), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [22:0] sb;
    } ent_t;

    ent_t m_q[$];
    int   m_outst;
    bit   m_err;
    int   m_phase;   // 0 accepting, 1 fence pending, 2 fence reported

    function automatic bit m_in_rdy();
        return (m_q.size() != DEPTH) && (m_phase == 0);
    endfunction
    function automatic bit m_vld();
        return (m_q.size() != 0) && (m_outst < MAX_OUTST);
    endfunction
    function automatic bit m_empty();
        return (m_q.size() == 0) && (m_outst == 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_outst = 0;
            m_err   = 0;
            m_phase = 0;
        end else begin
            bit   acc, iss, drained;
            ent_t e;
            acc     = in_vld && m_in_rdy();
            iss     = m_vld() && bus_req_rdy;
            drained = m_empty();
            if (iss) void'(m_q.pop_front());
            if (acc) begin
                e.a = in_addr; e.d = in_data; e.s = in_strb; e.sb = in_sb;
                m_q.push_back(e);
            end
            if (bus_ack_vld) begin
                if (m_outst == 0) m_err = 1;
                else m_outst--;
            end
            if (iss) m_outst++;
            if (m_phase == 0) begin
                if (fence_req) m_phase = 1;
            end else if (m_phase == 1) begin
                if (drained) m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("in_rdy", in_rdy, m_in_rdy());
        check("bus_req_vld", bus_req_vld, m_vld());
        check("outst_cnt", outst_cnt, m_outst);
        check("ack_err", ack_err, m_err);
        check("drain_empty", drain_empty, m_empty());
        check("fence_done", fence_done, m_phase == 2);
        if (m_vld()) begin
            check("bus_req_addr", bus_req_addr, m_q[0].a);
            check("bus_req_data", bus_req_data, m_q[0].d);
            check("bus_req_strb", bus_req_strb, m_q[0].s);
            check("bus_req_sb", bus_req_sb, m_q[0].sb);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int i;
        in_vld = 0; fence_req = 0; bus_req_rdy = 1;
        for (i = 0; i < 100 && !(m_empty() && m_phase == 0); i++) begin
            bus_ack_vld = (m_outst > 0);
            tick();
        end
        bus_ack_vld = 0;
        if (i == 100) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acks;
        bit  done;
        rst_n = 0; in_vld = 0; in_addr = 0; in_data = 0; in_strb = 0; in_sb = 0;
        bus_req_rdy = 0; bus_ack_vld = 0; fence_req = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // reset state
        check("rst_in_rdy", in_rdy, 1);
        check("rst_drain_empty", drain_empty, 1);
        check("rst_bus_req_vld", bus_req_vld, 0);
        check("rst_outst", outst_cnt, 0);

        // single store
        bus_req_rdy = 1; in_vld = 1;
        in_addr = 32'h100; in_data = 32'hDEADBEEF; in_strb = 4'hF; in_sb = 23'h12345;
        tick();
        in_vld = 0;
        check("single_vld", bus_req_vld, 1);
        check("single_addr", bus_req_addr, 32'h100);
        check("single_data", bus_req_data, 32'hDEADBEEF);
        check("single_strb", bus_req_strb, 4'hF);
        tick();
        check("single_outst1", outst_cnt, 1);
        check("single_vld_off", bus_req_vld, 0);
        bus_ack_vld = 1;
        tick();
        bus_ack_vld = 0;
        check("single_outst0", outst_cnt, 0);
        check("single_empty", drain_empty, 1);

        // full buffer: 5 offered, 4 taken, then in-order drain one per cycle
        bus_req_rdy = 0; in_vld = 1;
        for (int i = 0; i < 5; i++) begin
            in_addr = 32'h1000 + i; in_data = 32'hA000 + i;
            tick();
            if (i == 3) check("full_in_rdy_after4", in_rdy, 0);
        end
        in_vld = 0;
        check("full_in_rdy", in_rdy, 0);
        bus_req_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            check("full_drain_vld", bus_req_vld, 1);
            check("full_drain_order", bus_req_addr, 32'h1000 + i);
            bus_ack_vld = (m_outst > 0);
            tick();
        end
        check("full_drain_empty_buf", bus_req_vld, 0);
        drain();

        // outstanding limit
        bus_req_rdy = 0; in_vld = 1;
        for (int i = 0; i < 3; i++) begin
            in_addr = 32'h2000 + i; in_data = i;
            tick();
        end
        in_vld = 0; bus_req_rdy = 1;
        tick();
        tick();
        check("limit_vld_off", bus_req_vld, 0);
        check("limit_outst", outst_cnt, 2);
        check("limit_head", bus_req_addr, 32'h2002);
        check("limit_not_empty", drain_empty, 0);
        bus_ack_vld = 1;
        tick();
        bus_ack_vld = 0;
        check("limit_vld_back", bus_req_vld, 1);
        drain();

        // fence with 2 buffered and 1 outstanding
        bus_req_rdy = 0; in_vld = 1;
        for (int i = 0; i < 3; i++) begin
            in_addr = 32'h3000 + i;
            tick();
        end
        in_vld = 0; bus_req_rdy = 1;
        tick();
        bus_req_rdy = 0;
        check("fence_pre_outst", outst_cnt, 1);
        fence_req = 1;
        tick();
        fence_req = 0; in_vld = 1; in_addr = 32'h3300;
        acks = 0; done = 0;
        for (int i = 0; i < 40; i++) begin
            if (fence_done) begin
                done = 1;
                break;
            end
            check("fence_in_rdy_low", in_rdy, 0);
            bus_req_rdy = 1;
            bus_ack_vld = (m_outst > 0);
            if (bus_ack_vld) acks++;
            tick();
        end
        bus_ack_vld = 0;
        check("fence_done_seen", done, 1);
        check("fence_ack_count", acks, 3);
        check("fence_empty", drain_empty, 1);
        check("fence_in_rdy_done", in_rdy, 0);
        tick();
        check("fence_done_pulse", fence_done, 0);
        check("fence_in_rdy_idle", in_rdy, 1);
        tick();
        in_vld = 0;
        check("fence_held_accepted", bus_req_addr, 32'h3300);
        drain();

        // simultaneous issue+ack and enqueue+dequeue
        bus_req_rdy = 0; in_vld = 1;
        in_addr = 32'h400; tick();
        in_addr = 32'h404; tick();
        in_vld = 0; bus_req_rdy = 1;
        tick();
        check("simul_pre_outst", outst_cnt, 1);
        bus_ack_vld = 1; in_vld = 1; in_addr = 32'h408;
        tick();
        bus_ack_vld = 0; in_vld = 0; bus_req_rdy = 0;
        check("simul_outst", outst_cnt, 1);
        check("simul_vld", bus_req_vld, 1);
        check("simul_head", bus_req_addr, 32'h408);
        check("simul_in_rdy", in_rdy, 1);
        drain();

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            in_vld      = ($urandom_range(0, 3) != 0);
            in_addr     = $urandom;
            in_data     = $urandom;
            in_strb     = 4'($urandom);
            in_sb       = 23'($urandom);
            bus_req_rdy = ($urandom_range(0, 2) != 0);
            bus_ack_vld = (m_outst > 0) && ($urandom_range(0, 1) == 1);
            fence_req   = ($urandom_range(0, 19) == 0);
            tick();
        end
        drain();

        // spurious acknowledge
        bus_ack_vld = 1;
        tick();
        bus_ack_vld = 0;
        check("spur_ack_err", ack_err, 1);
        check("spur_outst", outst_cnt, 0);

        // reset with 3 buffered writes
        bus_req_rdy = 0; in_vld = 1;
        for (int i = 0; i < 3; i++) begin
            in_addr = 32'h5000 + i;
            tick();
        end
        in_vld = 0;
        check("prerst_vld", bus_req_vld, 1);
        rst_n = 0;
        #1;
        check("rst_mid_vld", bus_req_vld, 0);
        check("rst_mid_ack_err", ack_err, 0);
        check("rst_mid_in_rdy", in_rdy, 1);
        check("rst_mid_empty", drain_empty, 1);
        tick();
        rst_n = 1;
        tick();
        check("post_rst_vld", bus_req_vld, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/toy_st_drain.md
Name: toy_st_drain

Overview:
Store drain buffer placed directly downstream of the store queue's memory-request port. It accepts committed store writes over a valid/ready handshake and buffers them in a small FIFO. It issues them in order to the data-memory bus and bounds the number of un-acknowledged writes. It also implements a store fence: new stores are blocked until every buffered and outstanding write has been acknowledged, then the fence is reported complete.

Parameters:
DEPTH, 4, buffer entries; power of two, at least 2
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
SB_W, 23, sideband width; passed through unmodified
MAX_OUTST, 4, maximum bus writes issued but not yet acknowledged; 1 to 15

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
in_vld  in  1  store write request valid, from the store queue
in_rdy  out  1  buffer can accept a request
in_addr  in  ADDR_W  write address
in_data  in  DATA_W  write data
in_strb  in  DATA_W/8  byte strobes
in_sb  in  SB_W  sideband
bus_req_vld  out  1  bus write request valid
bus_req_rdy  in  1  bus accepts the request
bus_req_addr  out  ADDR_W  head-entry address
bus_req_data  out  DATA_W  head-entry data
bus_req_strb  out  DATA_W/8  head-entry strobes
bus_req_sb  out  SB_W  head-entry sideband
bus_ack_vld  in  1  one write acknowledged, one-cycle pulse
fence_req  in  1  fence request, one-cycle pulse
fence_done  out  1  fence complete, one-cycle pulse
drain_empty  out  1  buffer empty and no writes outstanding
outst_cnt  out  4  writes issued but not yet acknowledged
ack_err  out  1  sticky: acknowledge received while outst_cnt was 0

Behaviour:
- Reset values: all outputs 0, except in_rdy = 1 and drain_empty = 1. Read pointer, write pointer and count are 0. FSM is in IDLE.
- Buffer bookkeeping:
  - wr_ptr and rd_ptr are clog2(DEPTH) bits wide and wrap naturally.
  - cnt is clog2(DEPTH)+1 bits wide.
- Enqueue: in_fire = in_vld & in_rdy. The entry is written at wr_ptr at the clock edge.
- in_rdy = (cnt != DEPTH) & (state == IDLE). It is computed from registered state only; a same-cycle dequeue does not free space for an enqueue.
- No bypass: an entry written at edge N is presented on bus_req_* from cycle N+1 at the earliest.
- bus_req_vld = (cnt != 0) & (outst_cnt < MAX_OUTST). bus_req_* always carries the head entry (rd_ptr).
- Payload stability: once bus_req_vld is asserted, the payload is held stable until bus_req_rdy. The head cannot change without a dequeue, so this holds by construction.
- Dequeue: bus_fire = bus_req_vld & bus_req_rdy. rd_ptr increments on bus_fire.
- Count update:
  - Enqueue and dequeue in the same cycle: cnt unchanged.
  - Enqueue only: cnt + 1.
  - Dequeue only: cnt - 1.
- Outstanding counter:
  - Increments on bus_fire.
  - Decrements on bus_ack_vld when outst_cnt > 0.
  - bus_fire and an acknowledge in the same cycle: unchanged.
  - Acknowledge with outst_cnt == 0: counter stays 0 and ack_err is set. ack_err clears only on reset.
- drain_empty = (cnt == 0) & (outst_cnt == 0), from registered values.
- FSM:
  - IDLE: on fence_req, go to FENCE.
  - FENCE: in_rdy forced 0; draining continues. When drain_empty is 1, go to DONE.
  - DONE: fence_done = 1 for exactly this cycle; next state is IDLE.
  - fence_req outside IDLE is ignored; there is no queuing.
- Fence latency:
  - fence_req pulsed at edge N while already drained: FENCE in cycle N+1, DONE in cycle N+2. fence_done is high in cycle N+2.
  - Any in_vld presented while in FENCE or DONE is held off and accepted only after the return to IDLE.
- Reset asserted mid-operation: FSM, buffer and outstanding count are cleared immediately. Buffered writes are discarded.

Test Plan:
- Single store: DEPTH=4, bus_req_rdy=1; one in_fire of addr 0x100, data 0xDEADBEEF, strb 0xF. Required: bus_req_vld high exactly one cycle later with the same payload; outst_cnt = 1; after bus_ack_vld, outst_cnt = 0 and drain_empty = 1.
- Full buffer: bus_req_rdy=0; offer 5 stores back-to-back. Required: 4 accepted; in_rdy = 0 after the 4th; raising bus_req_rdy drains them in order 0,1,2,3, one per cycle.
- Outstanding limit: MAX_OUTST=2, no acknowledges, 3 stores buffered. Required: 2 bus fires, then bus_req_vld = 0 with cnt = 1. One acknowledge re-enables bus_req_vld the next cycle.
- Fence with 2 buffered writes and 1 outstanding: pulse fence_req. Required: in_rdy = 0 throughout; fence_done pulses one cycle after the third acknowledge brings drain_empty high.
- Simultaneous events: with outst_cnt = 1, drive bus_fire and bus_ack_vld in the same cycle, then enqueue and dequeue in the same cycle. Required: outst_cnt stays 1 and cnt is unchanged.
- Spurious acknowledge and reset: bus_ack_vld with outst_cnt = 0 sets ack_err = 1 while outst_cnt stays 0. Asserting rst_n = 0 with 3 buffered writes clears everything: bus_req_vld = 0, ack_err = 0, in_rdy = 1.
